// File: rtl/mips_pkg.sv
// Shared encodings, state types and arithmetic step helpers for the MIPS pipeline.
package mips_pkg;

   localparam int unsigned MD_CYCLES_DEFAULT = 32;

   typedef enum logic [2:0] {
      ALU_ADDU = 3'b000,
      ALU_SUBU = 3'b001,
      ALU_AND  = 3'b010,
      ALU_OR   = 3'b011,
      ALU_SLT  = 3'b100,
      ALU_SLTU = 3'b101,
      ALU_XOR  = 3'b110,
      ALU_LUI  = 3'b111
   } alu_op_e;

   localparam logic [2:0] MD_NONE  = 3'b000;
   localparam logic [2:0] MD_MFHI  = 3'b010;
   localparam logic [2:0] MD_MFLO  = 3'b011;
   localparam logic [2:0] MD_MULT  = 3'b100;
   localparam logic [2:0] MD_MULTU = 3'b101;
   localparam logic [2:0] MD_DIV   = 3'b110;
   localparam logic [2:0] MD_DIVU  = 3'b111;

   typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_e;

   typedef struct packed {
      logic [31:0] pc_four;
      logic [31:0] alu_result;
      logic [31:0] bus_b;
      logic [4:0]  rw;
      logic        mem_wr;
      logic        mem_to_reg;
      logic        reg_wr;
      logic        mem_read;
   } ex_mem_t;

   // One shift-add step: {hi,lo} holds partial product in hi and remaining multiplier in lo.
   function automatic logic [63:0] mul_step(input logic [63:0] p, input logic [31:0] m);
      logic [32:0] s;
      s = {1'b0, p[63:32]} + (p[0] ? {1'b0, m} : 33'd0);
      return {s, p[31:1]};
   endfunction

   // One restoring-division step: hi is the partial remainder, lo shifts dividend out / quotient in.
   function automatic logic [63:0] div_step(input logic [63:0] p, input logic [31:0] d);
      logic [32:0] r;
      logic [31:0] q;
      r = {p[63:32], p[31]};
      q = {p[30:0], 1'b0};
      if (r >= {1'b0, d}) begin
         r    = r - {1'b0, d};
         q[0] = 1'b1;
      end
      return {r[31:0], q};
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide sequencer with HI/LO; the final result is bypassed to hi/lo
// in the completing cycle so a waiting mfhi/mflo can leave EX on the edge that writes HI/LO.
module muldiv_unit
   import mips_pkg::*;
#(
   parameter int unsigned MD_CYCLES = MD_CYCLES_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned CW   = $clog2(MD_CYCLES + 1);
   localparam int unsigned BITS = (32 + MD_CYCLES - 1) / MD_CYCLES;

   md_state_e      state, state_nxt;
   logic [CW-1:0]  count_q;
   logic [6:0]     idx_q, step_k;
   logic [63:0]    work_q, step_w, prod;
   logic [31:0]    opb_q, hi_q, lo_q, quo, rem, fin_hi, fin_lo, a_mag, b_mag;
   logic           is_div_q, neg_q, rem_neg_q, dz_q;
   logic           a_neg, b_neg, finish, launch;

   // Signed ops (op[0] = 0) work on magnitudes
   assign a_neg  = !op[0] && a[31];
   assign b_neg  = !op[0] && b[31];
   assign a_mag  = a_neg ? -a : a;
   assign b_mag  = b_neg ? -b : b;
   assign finish = (state == MD_BUSY) && (count_q == CW'(1));
   assign busy   = (state == MD_BUSY) && !finish;
   assign launch = start && op[2] && !busy;

   // BITS steps per iteration so any MD_CYCLES covers all 32 bits
   always_comb begin
      step_w = work_q;
      step_k = idx_q;
      for (int unsigned i = 0; i < BITS; i++) begin
         if (step_k < 7'd32) begin
            step_w = is_div_q ? div_step(step_w, opb_q) : mul_step(step_w, opb_q);
            step_k = step_k + 7'd1;
         end
      end
   end

   always_comb begin
      prod   = neg_q ? -step_w : step_w;
      quo    = dz_q ? 32'hFFFF_FFFF : (neg_q ? -step_w[31:0] : step_w[31:0]);
      rem    = rem_neg_q ? -step_w[63:32] : step_w[63:32];
      fin_hi = is_div_q ? rem : prod[63:32];
      fin_lo = is_div_q ? quo : prod[31:0];
   end

   assign hi = finish ? fin_hi : hi_q;
   assign lo = finish ? fin_lo : lo_q;

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) state <= MD_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         MD_IDLE: if (launch) state_nxt = MD_BUSY;
         MD_BUSY: if (finish && !launch) state_nxt = MD_IDLE;
         default: state_nxt = MD_IDLE;
      endcase
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q   <= '0;
         idx_q     <= '0;
         work_q    <= '0;
         opb_q     <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         dz_q      <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         if (launch) begin
            count_q   <= CW'(MD_CYCLES);
            idx_q     <= '0;
            work_q    <= {32'd0, a_mag};
            opb_q     <= b_mag;
            is_div_q  <= op[1];
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            dz_q      <= (b == 32'd0);
         end else if (state == MD_BUSY) begin
            count_q <= count_q - CW'(1);
            work_q  <= step_w;
            idx_q   <= step_k;
         end
         if (finish) begin
            hi_q <= fin_hi;
            lo_q <= fin_lo;
         end
      end
   end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding, immediate extension, ALU, result select and the
// falling-edge EX/MEM register; stalls dependants of the multiply/divide unit.
module ex_stage
   import mips_pkg::*;
#(
   parameter int unsigned MD_CYCLES = MD_CYCLES_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc_four_3,
   input  logic [15:0] imm16_3,
   input  logic [31:0] busA_3,
   input  logic [31:0] busB_3,
   input  logic [4:0]  rs_3,
   input  logic [4:0]  rt_3,
   input  logic [4:0]  rd_3,
   input  logic        ExtOp_3,
   input  logic        ALUSrc_3,
   input  logic        RegDst_3,
   input  logic        MemWr_3,
   input  logic        MemtoReg_3,
   input  logic        RegWr_3,
   input  logic        MemRead_3,
   input  logic [2:0]  ALUctr_3,
   input  logic [2:0]  md_op_3,
   input  logic        wb_RegWr,
   input  logic [4:0]  wb_rw,
   input  logic [31:0] wb_data,
   output logic        md_stall,
   output logic [31:0] pc_four_4,
   output logic [31:0] alu_result_4,
   output logic [31:0] busB_4,
   output logic [4:0]  rw_4,
   output logic        MemWr_4,
   output logic        MemtoReg_4,
   output logic        RegWr_4,
   output logic        MemRead_4
);

   ex_mem_t     ex_mem_q, ex_mem_d;
   logic [31:0] fwd_a, fwd_b, imm32, src_b, alu, md_hi, md_lo;
   logic        md_busy;

   // EX/MEM takes priority over MEM/WB; r0 is never forwarded
   always_comb begin
      fwd_a = busA_3;
      if (ex_mem_q.reg_wr && ex_mem_q.rw != 5'd0 && ex_mem_q.rw == rs_3) fwd_a = ex_mem_q.alu_result;
      else if (wb_RegWr && wb_rw != 5'd0 && wb_rw == rs_3)              fwd_a = wb_data;
      fwd_b = busB_3;
      if (ex_mem_q.reg_wr && ex_mem_q.rw != 5'd0 && ex_mem_q.rw == rt_3) fwd_b = ex_mem_q.alu_result;
      else if (wb_RegWr && wb_rw != 5'd0 && wb_rw == rt_3)              fwd_b = wb_data;
   end

   assign imm32 = ExtOp_3 ? {{16{imm16_3[15]}}, imm16_3} : {16'd0, imm16_3};
   assign src_b = ALUSrc_3 ? imm32 : fwd_b;

   always_comb begin
      alu = '0;
      case (ALUctr_3)
         ALU_ADDU: alu = fwd_a + src_b;
         ALU_SUBU: alu = fwd_a - src_b;
         ALU_AND:  alu = fwd_a & src_b;
         ALU_OR:   alu = fwd_a | src_b;
         ALU_SLT:  alu = {31'd0, $signed(fwd_a) < $signed(src_b)};
         ALU_SLTU: alu = {31'd0, fwd_a < src_b};
         ALU_XOR:  alu = fwd_a ^ src_b;
         ALU_LUI:  alu = {imm16_3, 16'd0};
         default:  alu = '0;
      endcase
   end

   muldiv_unit #(.MD_CYCLES(MD_CYCLES)) u_muldiv (
      .clk   (clk),
      .rst_n (rst_n),
      .start (md_op_3[2]),
      .op    (md_op_3),
      .a     (fwd_a),
      .b     (fwd_b),
      .busy  (md_busy),
      .hi    (md_hi),
      .lo    (md_lo)
   );

   assign md_stall = md_busy && (md_op_3 != MD_NONE);

   // A stalled instruction stays in ID/EX; EX/MEM gets a bubble meanwhile
   always_comb begin
      ex_mem_d.pc_four    = pc_four_3;
      ex_mem_d.alu_result = (md_op_3 == MD_MFHI) ? md_hi :
                            (md_op_3 == MD_MFLO) ? md_lo : alu;
      ex_mem_d.bus_b      = fwd_b;
      ex_mem_d.rw         = RegDst_3 ? rd_3 : rt_3;
      ex_mem_d.mem_wr     = MemWr_3 && !md_stall;
      ex_mem_d.mem_to_reg = MemtoReg_3 && !md_stall;
      ex_mem_d.reg_wr     = RegWr_3 && !md_stall;
      ex_mem_d.mem_read   = MemRead_3 && !md_stall;
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) ex_mem_q <= '0;
      else        ex_mem_q <= ex_mem_d;
   end

   assign pc_four_4    = ex_mem_q.pc_four;
   assign alu_result_4 = ex_mem_q.alu_result;
   assign busB_4       = ex_mem_q.bus_b;
   assign rw_4         = ex_mem_q.rw;
   assign MemWr_4      = ex_mem_q.mem_wr;
   assign MemtoReg_4   = ex_mem_q.mem_to_reg;
   assign RegWr_4      = ex_mem_q.reg_wr;
   assign MemRead_4    = ex_mem_q.mem_read;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage (falling-edge pipeline register).
module tb_ex_stage;
   import mips_pkg::*;

   localparam int unsigned MDC = 16;

   logic        clk, rst_n;
   logic [31:0] pc_four_3, busA_3, busB_3, wb_data;
   logic [15:0] imm16_3;
   logic [4:0]  rs_3, rt_3, rd_3, wb_rw;
   logic        ExtOp_3, ALUSrc_3, RegDst_3, MemWr_3, MemtoReg_3, RegWr_3, MemRead_3, wb_RegWr;
   logic [2:0]  ALUctr_3, md_op_3;
   logic        md_stall;
   logic [31:0] pc_four_4, alu_result_4, busB_4;
   logic [4:0]  rw_4;
   logic        MemWr_4, MemtoReg_4, RegWr_4, MemRead_4;

   int n_cmp = 0;
   int n_err = 0;

   logic [2:0]  ctr_v [6] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
   logic [31:0] a_v   [6] = '{32'd3, 32'hF0F0_1234, 32'h0000_00F0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hAAAA_5555};
   logic [31:0] b_v   [6] = '{32'd5, 32'h0FF0_FF00, 32'h0000_000F, 32'd1, 32'd1, 32'hFFFF_0000};
   logic [31:0] e_v   [6] = '{32'hFFFF_FFFE, 32'h00F0_1200, 32'h0000_00FF, 32'd1, 32'd0, 32'h5555_5555};

   ex_stage #(.MD_CYCLES(MDC)) dut (
      .clk(clk), .rst_n(rst_n), .pc_four_3(pc_four_3), .imm16_3(imm16_3),
      .busA_3(busA_3), .busB_3(busB_3), .rs_3(rs_3), .rt_3(rt_3), .rd_3(rd_3),
      .ExtOp_3(ExtOp_3), .ALUSrc_3(ALUSrc_3), .RegDst_3(RegDst_3), .MemWr_3(MemWr_3),
      .MemtoReg_3(MemtoReg_3), .RegWr_3(RegWr_3), .MemRead_3(MemRead_3),
      .ALUctr_3(ALUctr_3), .md_op_3(md_op_3), .wb_RegWr(wb_RegWr), .wb_rw(wb_rw),
      .wb_data(wb_data), .md_stall(md_stall), .pc_four_4(pc_four_4),
      .alu_result_4(alu_result_4), .busB_4(busB_4), .rw_4(rw_4), .MemWr_4(MemWr_4),
      .MemtoReg_4(MemtoReg_4), .RegWr_4(RegWr_4), .MemRead_4(MemRead_4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      pc_four_3 = '0; imm16_3 = '0; busA_3 = '0; busB_3 = '0;
      rs_3 = '0; rt_3 = '0; rd_3 = '0;
      ExtOp_3 = 0; ALUSrc_3 = 0; RegDst_3 = 0; MemWr_3 = 0; MemtoReg_3 = 0; RegWr_3 = 0; MemRead_3 = 0;
      ALUctr_3 = '0; md_op_3 = '0; wb_RegWr = 0; wb_rw = '0; wb_data = '0;
   endtask

   task automatic wait_stall(output int n);
      n = 0;
      while (md_stall && n < 200) begin
         tick();
         n++;
      end
   endtask

   // Issue an md op, then mflo immediately (waiting out the stall), then mfhi
   task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi_o, output logic [31:0] lo_o, output int stalls);
      clear_inputs(); md_op_3 = op; busA_3 = a; busB_3 = b;
      tick();
      clear_inputs(); md_op_3 = MD_MFLO; RegWr_3 = 1; RegDst_3 = 1; rd_3 = 5'd10;
      #1;
      wait_stall(stalls);
      tick();
      lo_o = alu_result_4;
      md_op_3 = MD_MFHI;
      tick();
      hi_o = alu_result_4;
   endtask

   task automatic test_reset;
      rst_n = 1;
      clear_inputs();
      #1 rst_n = 0;
      #1;
      n_cmp++; if ({pc_four_4, alu_result_4, busB_4, rw_4, MemWr_4, MemtoReg_4, RegWr_4, MemRead_4} !== '0) begin n_err++; $display("FAIL reset_outputs: got alu=%h rw=%h RegWr=%b, want all zero", alu_result_4, rw_4, RegWr_4); end
      n_cmp++; if (md_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b, want 0", md_stall); end
      busA_3 = 32'd5; ALUSrc_3 = 1; imm16_3 = 16'd1; RegWr_3 = 1; rt_3 = 5'd4;
      tick();
      n_cmp++; if ({alu_result_4, RegWr_4, rw_4} !== '0) begin n_err++; $display("FAIL reset_hold: got alu=%h RegWr=%b rw=%h, want 0", alu_result_4, RegWr_4, rw_4); end
      rst_n = 1;
   endtask

   task automatic test_alu_imm;
      clear_inputs();
      pc_four_3 = 32'h0040_0004; busA_3 = 32'd5; imm16_3 = 16'hFFFF; ExtOp_3 = 1; ALUSrc_3 = 1;
      ALUctr_3 = ALU_ADDU; rs_3 = 5'd1; rt_3 = 5'd8; RegWr_3 = 1;
      tick();
      n_cmp++; if (alu_result_4 !== 32'd4) begin n_err++; $display("FAIL addiu_sext: got %h, want %h", alu_result_4, 32'd4); end
      n_cmp++; if ({pc_four_4, rw_4, RegWr_4} !== {32'h0040_0004, 5'd8, 1'b1}) begin n_err++; $display("FAIL pipe_fields: got pc=%h rw=%0d RegWr=%b, want pc=00400004 rw=8 RegWr=1", pc_four_4, rw_4, RegWr_4); end
      ALUctr_3 = ALU_LUI;
      tick();
      n_cmp++; if (alu_result_4 !== 32'hFFFF_0000) begin n_err++; $display("FAIL lui: got %h, want ffff0000", alu_result_4); end
      ALUctr_3 = ALU_ADDU; ExtOp_3 = 0;
      tick();
      n_cmp++; if (alu_result_4 !== 32'h0001_0004) begin n_err++; $display("FAIL addiu_zext: got %h, want 00010004", alu_result_4); end
      ALUSrc_3 = 0; RegDst_3 = 1; rd_3 = 5'd9; rt_3 = 5'd2;
      for (int i = 0; i < 6; i++) begin
         ALUctr_3 = ctr_v[i]; busA_3 = a_v[i]; busB_3 = b_v[i];
         tick();
         n_cmp++; if (alu_result_4 !== e_v[i]) begin n_err++; $display("FAIL alu_op%0d: got %h, want %h", ctr_v[i], alu_result_4, e_v[i]); end
      end
      n_cmp++; if ({rw_4, busB_4} !== {5'd9, 32'hFFFF_0000}) begin n_err++; $display("FAIL regdst_store: got rw=%0d busB=%h, want rw=9 busB=ffff0000", rw_4, busB_4); end
   endtask

   task automatic test_forwarding;
      clear_inputs(); ALUSrc_3 = 1; RegWr_3 = 1; rs_3 = 5'd1; busA_3 = 32'd7; rt_3 = 5'd3;
      tick();
      rs_3 = 5'd3; busA_3 = 32'd100; rt_3 = 5'd4; wb_RegWr = 1; wb_rw = 5'd3; wb_data = 32'd9;
      tick();
      n_cmp++; if (alu_result_4 !== 32'd7) begin n_err++; $display("FAIL fwd_exmem_prio: got %h, want 7", alu_result_4); end
      rt_3 = 5'd5;
      tick();
      n_cmp++; if (alu_result_4 !== 32'd9) begin n_err++; $display("FAIL fwd_memwb: got %h, want 9", alu_result_4); end
      clear_inputs(); ALUctr_3 = ALU_OR; rs_3 = 5'd6; rt_3 = 5'd5; busB_3 = 32'd1; MemWr_3 = 1;
      tick();
      n_cmp++; if ({alu_result_4, busB_4, MemWr_4, RegWr_4} !== {32'd9, 32'd9, 1'b1, 1'b0}) begin n_err++; $display("FAIL fwd_b_store: got alu=%h busB=%h MemWr=%b RegWr=%b, want 9 9 1 0", alu_result_4, busB_4, MemWr_4, RegWr_4); end
      clear_inputs(); ALUSrc_3 = 1; RegWr_3 = 1; rs_3 = 5'd1; busA_3 = 32'd7; rt_3 = 5'd0;
      tick();
      rs_3 = 5'd0; busA_3 = 32'd55; rt_3 = 5'd2; wb_RegWr = 1; wb_rw = 5'd0; wb_data = 32'd9;
      tick();
      n_cmp++; if (alu_result_4 !== 32'd55) begin n_err++; $display("FAIL fwd_r0: got %h, want 37", alu_result_4); end
   endtask

   task automatic test_multu_mflo;
      int stalls, bubble_bad;
      clear_inputs(); md_op_3 = MD_MULTU; busA_3 = 32'hFFFF_FFFF; busB_3 = 32'd2;
      #1;
      n_cmp++; if (md_stall !== 1'b0) begin n_err++; $display("FAIL issue_no_stall: got %b, want 0", md_stall); end
      tick();
      clear_inputs(); md_op_3 = MD_MFLO; RegWr_3 = 1; RegDst_3 = 1; rd_3 = 5'd10;
      #1;
      stalls = 0; bubble_bad = 0;
      while (md_stall && stalls < 200) begin
         tick();
         stalls++;
         if (RegWr_4 || MemWr_4 || MemRead_4 || MemtoReg_4) bubble_bad++;
      end
      n_cmp++; if (stalls !== int'(MDC - 1)) begin n_err++; $display("FAIL stall_edges: got %0d, want %0d", stalls, MDC - 1); end
      n_cmp++; if (bubble_bad !== 0) begin n_err++; $display("FAIL bubbles: got %0d non-bubble edges, want 0", bubble_bad); end
      tick();
      n_cmp++; if ({alu_result_4, rw_4, RegWr_4} !== {32'hFFFF_FFFE, 5'd10, 1'b1}) begin n_err++; $display("FAIL multu_lo: got %h rw=%0d RegWr=%b, want fffffffe rw=10 RegWr=1", alu_result_4, rw_4, RegWr_4); end
      md_op_3 = MD_MFHI;
      #1;
      n_cmp++; if (md_stall !== 1'b0) begin n_err++; $display("FAIL mfhi_idle_stall: got %b, want 0", md_stall); end
      tick();
      n_cmp++; if (alu_result_4 !== 32'd1) begin n_err++; $display("FAIL multu_hi: got %h, want 1", alu_result_4); end
   endtask

   task automatic test_div;
      logic [31:0] hi, lo;
      int st;
      run_md(MD_DIV, 32'hFFFF_FFF9, 32'd2, hi, lo, st);
      n_cmp++; if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin n_err++; $display("FAIL div_neg: got hi=%h lo=%h, want ffffffff fffffffd", hi, lo); end
      n_cmp++; if (st !== int'(MDC - 1)) begin n_err++; $display("FAIL div_stall: got %0d, want %0d", st, MDC - 1); end
      run_md(MD_DIV, 32'd12, 32'd0, hi, lo, st);
      n_cmp++; if ({hi, lo} !== {32'd12, 32'hFFFF_FFFF}) begin n_err++; $display("FAIL div_zero: got hi=%h lo=%h, want 0000000c ffffffff", hi, lo); end
      n_cmp++; if (st !== int'(MDC - 1)) begin n_err++; $display("FAIL divz_stall: got %0d, want %0d", st, MDC - 1); end
      run_md(MD_DIV, 32'd7, 32'hFFFF_FFFE, hi, lo, st);
      n_cmp++; if ({hi, lo} !== {32'd1, 32'hFFFF_FFFD}) begin n_err++; $display("FAIL div_negdivisor: got hi=%h lo=%h, want 00000001 fffffffd", hi, lo); end
      run_md(MD_DIVU, 32'd100, 32'd7, hi, lo, st);
      n_cmp++; if ({hi, lo} !== {32'd2, 32'd14}) begin n_err++; $display("FAIL divu: got hi=%h lo=%h, want 2 e", hi, lo); end
      run_md(MD_MULT, 32'hFFFF_FFFD, 32'd5, hi, lo, st);
      n_cmp++; if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFF1}) begin n_err++; $display("FAIL mult_neg: got hi=%h lo=%h, want ffffffff fffffff1", hi, lo); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] hi, lo;
      int st;
      clear_inputs(); md_op_3 = MD_MULTU; busA_3 = 32'd3; busB_3 = 32'd4;
      tick();
      clear_inputs(); rs_3 = 5'd1; busA_3 = 32'd20; ALUSrc_3 = 1; imm16_3 = 16'd22; rt_3 = 5'd11; RegWr_3 = 1;
      #1;
      n_cmp++; if (md_stall !== 1'b0) begin n_err++; $display("FAIL busy_indep_stall: got %b, want 0", md_stall); end
      tick();
      n_cmp++; if ({alu_result_4, RegWr_4} !== {32'd42, 1'b1}) begin n_err++; $display("FAIL busy_indep_addu: got %h RegWr=%b, want 2a 1", alu_result_4, RegWr_4); end
      clear_inputs(); md_op_3 = MD_MULT; busA_3 = 32'hFFFF_FFFE; busB_3 = 32'd3;
      #1;
      wait_stall(st);
      n_cmp++; if (st !== int'(MDC - 2)) begin n_err++; $display("FAIL second_mult_stall: got %0d, want %0d", st, MDC - 2); end
      tick();
      clear_inputs(); md_op_3 = MD_MFLO; RegWr_3 = 1; RegDst_3 = 1; rd_3 = 5'd10;
      #1;
      wait_stall(st);
      tick();
      lo = alu_result_4;
      md_op_3 = MD_MFHI;
      tick();
      hi = alu_result_4;
      n_cmp++; if ({hi, lo, st} !== {32'hFFFF_FFFF, 32'hFFFF_FFFA, int'(MDC - 1)}) begin n_err++; $display("FAIL second_mult_result: got hi=%h lo=%h stalls=%0d, want ffffffff fffffffa %0d", hi, lo, st, MDC - 1); end
   endtask

   task automatic test_reset_mid;
      int st;
      clear_inputs(); md_op_3 = MD_MULT; busA_3 = 32'd1000; busB_3 = 32'd1000;
      tick();
      clear_inputs(); pc_four_3 = 32'h0000_0100; rs_3 = 5'd1; busA_3 = 32'h1234; ALUSrc_3 = 1; rt_3 = 5'd12; RegWr_3 = 1;
      repeat (10) tick();
      md_op_3 = MD_MFLO;
      #1;
      n_cmp++; if ({md_stall, alu_result_4} !== {1'b1, 32'h1234}) begin n_err++; $display("FAIL pre_reset_busy: got stall=%b alu=%h, want 1 1234", md_stall, alu_result_4); end
      #2 rst_n = 0;
      #1;
      n_cmp++; if (md_stall !== 1'b0) begin n_err++; $display("FAIL midreset_stall: got %b, want 0", md_stall); end
      n_cmp++; if ({pc_four_4, alu_result_4, busB_4, rw_4, MemWr_4, MemtoReg_4, RegWr_4, MemRead_4} !== '0) begin n_err++; $display("FAIL midreset_outputs: got pc=%h alu=%h rw=%0d RegWr=%b, want all zero", pc_four_4, alu_result_4, rw_4, RegWr_4); end
      tick();
      rst_n = 1;
      clear_inputs(); md_op_3 = MD_MFLO; RegWr_3 = 1; RegDst_3 = 1; rd_3 = 5'd10;
      #1;
      wait_stall(st);
      n_cmp++; if (st !== 0) begin n_err++; $display("FAIL postreset_stall: got %0d, want 0", st); end
      tick();
      n_cmp++; if (alu_result_4 !== 32'd0) begin n_err++; $display("FAIL postreset_lo: got %h, want 0", alu_result_4); end
      md_op_3 = MD_MFHI;
      tick();
      n_cmp++; if (alu_result_4 !== 32'd0) begin n_err++; $display("FAIL postreset_hi: got %h, want 0", alu_result_4); end
   endtask

   initial begin
      test_reset();
      test_alu_imm();
      test_forwarding();
      test_multu_mflo();
      test_div();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. It sits directly downstream of the ID/EX register and consumes its `_3` fields.
- Functions: operand forwarding, immediate extension, ALU, destination-register select, an iterative multiply/divide unit with HI/LO registers, and the EX/MEM pipeline register that drives the `_4` fields into MEM.
- Raises `md_stall` toward the hazard logic while a dependent instruction waits on the multiply/divide unit.

Parameters:
- MD_CYCLES, 32, iterations per multiply/divide operation; must be at least 1.

Ports:
- clk  in  1  pipeline clock; all state updates on the falling edge, like the other pipeline registers
- rst_n  in  1  asynchronous active-low reset
- pc_four_3  in  32  PC+4 of the instruction in EX
- imm16_3  in  16  raw immediate
- busA_3, busB_3  in  32  register-file operands read in ID
- rs_3, rt_3, rd_3  in  5  register specifiers
- ExtOp_3, ALUSrc_3, RegDst_3, MemWr_3, MemtoReg_3, RegWr_3, MemRead_3  in  1  decoded controls
- ALUctr_3  in  3  ALU operation
- md_op_3  in  3  multiply/divide operation: 000 none, 010 mfhi, 011 mflo, 100 mult, 101 multu, 110 div, 111 divu
- wb_RegWr  in  1  MEM/WB write enable, used for forwarding
- wb_rw  in  5  MEM/WB destination register
- wb_data  in  32  MEM/WB write-back data
- md_stall  out  1  combinational; tells upstream to hold the PC, IF/ID and ID/EX contents (hold, not bubble)
- pc_four_4, alu_result_4, busB_4  out  32  EX/MEM data; busB_4 is the forwarded store data
- rw_4  out  5  destination register
- MemWr_4, MemtoReg_4, RegWr_4, MemRead_4  out  1  EX/MEM controls

Behaviour:
- Reset: all `_4` outputs = 0; HI = LO = 0; md unit idle with counter 0; md_stall = 0. Reset is asynchronous and may abort an operation in progress; HI/LO are then 0.

Forwarding, per operand (rs for A, rt for B):
- Priority 1: EX/MEM, when RegWr_4 = 1, rw_4 = rs/rt and rw_4 != 0; the value taken is alu_result_4.
- Priority 2: MEM/WB, when wb_RegWr = 1, wb_rw = rs/rt and wb_rw != 0; the value taken is wb_data.
- Otherwise busA_3 / busB_3.
- Load-use stalls are handled upstream and are out of scope here.

Immediate and ALU inputs:
- imm32 = ExtOp_3 ? sign-extend(imm16_3) : zero-extend(imm16_3).
- srcB = ALUSrc_3 ? imm32 : forwarded B.

ALUctr_3 encoding:
- 000 addu
- 001 subu
- 010 and
- 011 or
- 100 slt (signed)
- 101 sltu
- 110 xor
- 111 lui: imm16_3 << 16
- Arithmetic wraps; there is no overflow trap.

Destination and result:
- rw = RegDst_3 ? rd_3 : rt_3.
- Result mux: md_op_3 = 010 gives HI, 011 gives LO, otherwise the ALU result.

EX/MEM register:
- One-cycle latency: on each falling edge the `_4` fields load from EX.
- When md_stall = 1, the register loads a bubble instead: all four controls = 0, data don't-care.

Multiply/divide unit:
- States: IDLE and BUSY.
- IDLE to BUSY: when md_op_3[2] = 1 and the unit is IDLE, capture the forwarded A and B and load counter = MD_CYCLES.
- The issuing instruction leaves EX normally in that cycle and writes no GPR.
- BUSY: one iteration per edge, counter decrements. At counter = 1, write HI/LO and return to IDLE.
- mult/multu: shift-add 64-bit product; HI = upper 32 bits, LO = lower 32 bits. Signed ops work on magnitudes and negate the result when the operand signs differ.
- div/divu: restoring division; LO = quotient, HI = remainder. For signed ops the quotient is negative when the signs differ and the remainder takes the sign of the dividend.
- Divide by zero: LO = 32'hFFFF_FFFF, HI = dividend. Latency is still MD_CYCLES.
- md_stall = 1 while BUSY and md_op_3 != 000, i.e. a new md op or an mfhi/mflo is in EX. It deasserts in the cycle HI/LO are written.
- The stalled instruction re-evaluates on the next edge and sees the new HI/LO.
- Non-md instructions proceed while the unit is BUSY.

Decomposition:
- Shared package `mips_pkg`:
  - ALUctr encodings
  - md_op encodings
  - md state enum
  - MD_CYCLES default
- Sub-module `muldiv_unit`: inputs start, op, a, b; outputs busy, hi, lo. The sequencer and the HI/LO registers live there.
- Forwarding, ALU and the EX/MEM register stay in `ex_stage`.

Test Plan:
1. Reset mid-multiply: issue mult, pulse rst_n low at iteration 10 → HI = LO = 0, md_stall = 0, all `_4` fields 0 without waiting for a clock edge.
2. ALU plus immediate: busA_3 = 5, imm16_3 = 16'hFFFF, ExtOp_3 = 1, ALUSrc_3 = 1, ALUctr_3 = 000 → alu_result_4 = 4 after one falling edge. The same stimulus with ALUctr_3 = 111 gives 32'hFFFF_0000.
3. Forwarding priority: previous instruction writes r3 = 7 (EX/MEM), wb writes r3 = 9, current rs_3 = 3 → A = 7. Repeat with the destination r0 → A = busA_3.
4. multu followed immediately by mflo: A = 32'hFFFF_FFFF, B = 2 → md_stall high for exactly MD_CYCLES-1 edges with bubbles in EX/MEM, then alu_result_4 = 32'hFFFF_FFFE; HI = 1.
5. Signed div: A = -7, B = 2 → LO = -3, HI = -1. div by 0 with A = 12 → LO = 32'hFFFF_FFFF, HI = 12.
6. Independent addu issued during BUSY → no stall and a correct result. A second mult issued during BUSY → stalls until IDLE, then starts.
